pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and pipeline-control block for the 5-stage MIPS pipeline: IF, ID, EXE, MEM, WB. It generalises the existing forwarding unit. It adds load-use stall detection, taken-branch flush of the younger stages, and a multi-cycle EXE-occupancy state machine for long-latency ops (mul/div). It also keeps saturating stall and flush performance counters. It sits beside the pipeline registers and drives their write-enable, bubble and flush inputs plus the forward-mux selects.

## Interface
- `ADDR_W`, 5, register-address width
- `MULTI_LAT`, 4, total EXE cycles occupied by a multi-cycle op; must be ≥1
- `CNT_W`, 16, performance-counter width

- `clk` in 1, pipeline clock
- `rst` in 1, reset, synchronous, active-high; one clock
- `id_rs`, `id_rt` in ADDR_W, source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1, the ID instruction reads that source
- `ex_rs`, `ex_rt` in ADDR_W, source registers of the instruction in EXE
- `ex_dst` in ADDR_W, destination of the EXE instruction
- `ex_reg_write`, `ex_mem_read` in 1, EXE instruction writes a register / is a load
- `ex_multi_start` in 1, EXE instruction is a multi-cycle op; sampled only in RUN
- `mem_dst`, `wb_dst` in ADDR_W, destinations in MEM and WB
- `mem_reg_write`, `wb_reg_write` in 1, MEM / WB write-back enables
- `mem_branch_taken` in 1, branch resolved taken in MEM
- `pc_write`, `if_id_write`, `id_ex_write` out 1, register enables; 1 means advance
- `id_ex_bubble`, `ex_mem_bubble` out 1, load zeroed control (NOP) into that register
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1, squash that register's contents
- `fwd_rs`, `fwd_rt` out 2, forward select: 00 regfile, 01 WB data, 10 MEM result
- `ex_busy` out 1, multi-cycle op occupying EXE
- `stall_cnt`, `flush_cnt` out CNT_W, saturating event counters

## Operation
**FSM states**
- RUN: normal operation.
- MULTI: a multi-cycle op is held in EXE. Holds down-counter `cnt`, width clog2(MULTI_LAT)+1.

**Priority each cycle:** branch flush > multi-cycle stall > load-use stall.

**Branch flush** (`mem_branch_taken`=1)
- Outputs: `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1, `pc_write`=1, all bubbles 0.
- If in MULTI, the younger multi op is aborted: next state RUN, `cnt`←0.
- `flush_cnt`++.

**Multi-cycle**
- RUN with `ex_multi_start`=1 and MULTI_LAT≥2: stall this cycle, state←MULTI, `cnt`←MULTI_LAT−2.
- In MULTI with `cnt`≠0: stall, `cnt`−−.
- In MULTI with `cnt`=0: no stall (result valid, pipeline advances), state←RUN.
- Multi stall outputs: `pc_write`=`if_id_write`=`id_ex_write`=0, `ex_mem_bubble`=1, `ex_busy`=1.
- MULTI_LAT=1: never leaves RUN, never stalls.

**Load-use stall**
- Condition: `ex_mem_read` & `ex_reg_write` & `ex_dst`≠0 & ((`id_uses_rs` & `ex_dst`==`id_rs`) | (`id_uses_rt` & `ex_dst`==`id_rt`)).
- Outputs: `pc_write`=`if_id_write`=0, `id_ex_bubble`=1, `id_ex_write`=1.
- Lasts one cycle; it clears naturally once the load advances.

**Counters**
- `stall_cnt`++ on every cycle with a multi or load-use stall.
- Both counters saturate at all-ones.

**Forwarding** (per source, combinational)
- MEM match (`mem_reg_write`, `mem_dst`≠0, `mem_dst`==src) → 10.
- Else WB match → 01.
- Else 00.
- Register 0 is never forwarded.

## Timing
- **Reset values**, while `rst`=1 and on the cycle after:
  - State RUN, `cnt`=0, counters 0.
  - `pc_write`=`if_id_write`=`id_ex_write`=0; all flushes 1; bubbles 0.
  - `fwd_*`=00, `ex_busy`=0.
- **Reset mid-MULTI:** abort to RUN on the next edge.
- **Latency:** all control and forward outputs are combinational from inputs and current state, valid in the same cycle. State, `cnt` and counters update on the rising `clk` edge.
- **Simultaneous events:**
  - Branch and load-use in the same cycle: flush only, no stall, `stall_cnt` unchanged.
  - `ex_multi_start` is ignored while in MULTI.

## Structure
- Shared package `pipe_pkg`:
  - forward-select constants FWD_REG/FWD_WB/FWD_MEM;
  - FSM state enum {RUN, MULTI};
  - control-bundle field widths.
- Sub-module `pipe_fwd_sel`: one source-register forward decision, instantiated twice (rs, rt).
- FSM, stall/flush logic and counters live in the top module.

## Test plan
1. Reset: hold `rst` 2 cycles → all flushes 1, enables 0, counters 0, `fwd_*`=00.
2. Load-use: EXE `lw` with `ex_dst`=8, ID `id_rs`=8 with `id_uses_rs`=1 → one cycle of `pc_write`=0, `id_ex_bubble`=1, `stall_cnt`=1. Repeat with `ex_dst`=0 → no stall.
3. Forwarding: `mem_dst`=`wb_dst`=`ex_rs`=9, both writing → `fwd_rs`=10. Drop `mem_reg_write` → 01. `ex_rt`=0 → `fwd_rt`=00.
4. Multi-cycle, MULTI_LAT=4: pulse `ex_multi_start` → exactly 3 stall cycles with `ex_busy`=1, 4th cycle advances, `stall_cnt`=3.
5. Branch during MULTI, plus same cycle as a load-use hazard: `mem_branch_taken` on the 2nd stall cycle → three flushes, state RUN next cycle, `flush_cnt`=1, no load-use stall counted.
6. Saturation: CNT_W=4, 20 load-use stalls → `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/control slice: forward-select
// codes, FSM state type and the per-cycle control bundle.
package pipe_pkg;

  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  // Pipeline-register control driven each cycle.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic ex_busy;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Held pipeline with every register squashed.
  localparam ctrl_t CTRL_RESET = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                   ex_mem_flush: 1'b1, default: 1'b0};
  // Everything advances.
  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1,
                                   id_ex_write: 1'b1, default: 1'b0};
  // Taken branch: fetch the target, squash the three younger stages.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1,
                                   id_ex_write: 1'b1, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
                                   default: 1'b0};
  // Long-latency op holds EXE; a NOP drains into MEM behind it.
  localparam ctrl_t CTRL_MSTALL = '{ex_mem_bubble: 1'b1, ex_busy: 1'b1,
                                    default: 1'b0};
  // Load-use: hold IF/ID, let the load move on, put a NOP into EXE.
  localparam ctrl_t CTRL_LDUSE = '{id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                   default: 1'b0};

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forward-mux select for one EXE source register.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic              wb_reg_write,
  output logic [FWD_W-1:0]  sel
);

  // Youngest producer wins; register 0 is hard-wired and never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control for the 5-stage pipeline: branch flush,
// multi-cycle EXE occupancy, load-use stall, forwarding and event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_multi_start,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              mem_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned    CW       = $clog2(MULTI_LAT) + 1;
  localparam bit             MULTI_EN = (MULTI_LAT >= 2);
  localparam logic [CW-1:0]  CNT_INIT = MULTI_EN ? CW'(MULTI_LAT - 2) : '0;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              rst_q, rst_d;
  logic              in_rst;
  logic              load_use;
  logic              stall_ev, flush_ev;
  ctrl_t             ctrl;
  logic [FWD_W-1:0]  fwd_rs_raw, fwd_rt_raw;

  pipe_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_rs (
    .src           (ex_rs),
    .mem_dst       (mem_dst),
    .mem_reg_write (mem_reg_write),
    .wb_dst        (wb_dst),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_rs_raw)
  );

  pipe_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_rt (
    .src           (ex_rt),
    .mem_dst       (mem_dst),
    .mem_reg_write (mem_reg_write),
    .wb_dst        (wb_dst),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_rt_raw)
  );

  // Control is held in its reset shape for the reset cycle and one after.
  assign in_rst = rst | rst_q;
  assign rst_d  = rst;

  assign load_use = ex_mem_read && ex_reg_write && (ex_dst != '0) &&
                    ((id_uses_rs && (ex_dst == id_rs)) ||
                     (id_uses_rt && (ex_dst == id_rt)));

  // Prioritised control decision and next FSM state: branch > multi > load-use.
  always_comb begin
    ctrl     = CTRL_RUN;
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (in_rst) begin
      ctrl    = CTRL_RESET;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (mem_branch_taken) begin
      ctrl     = CTRL_FLUSH;
      flush_ev = 1'b1;
      state_d  = ST_RUN;
      cnt_d    = '0;
    end else if ((state_q == ST_MULTI) && (cnt_q != '0)) begin
      ctrl     = CTRL_MSTALL;
      stall_ev = 1'b1;
      cnt_d    = cnt_q - CW'(1);
    end else if ((state_q == ST_RUN) && ex_multi_start && MULTI_EN) begin
      ctrl     = CTRL_MSTALL;
      stall_ev = 1'b1;
      state_d  = ST_MULTI;
      cnt_d    = CNT_INIT;
    end else begin
      // Final MULTI cycle advances like RUN, so a load-use hazard may still apply.
      state_d = ST_RUN;
      if (load_use) begin
        ctrl     = CTRL_LDUSE;
        stall_ev = 1'b1;
      end
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State, occupancy counter, event counters and reset tail flag.
  always_ff @(posedge clk) begin
    rst_q <= rst_d;
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_flush  = ctrl.ex_mem_flush;
  assign ex_busy       = ctrl.ex_busy;
  assign fwd_rs        = in_rst ? FWD_REG : fwd_rs_raw;
  assign fwd_rt        = in_rst ? FWD_REG : fwd_rt_raw;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW   = 5;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic          id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic          ex_multi_start, mem_reg_write, wb_reg_write, mem_branch_taken;
  logic          pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, ex_busy;
  logic [1:0]    fwd_rs, fwd_rt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: cycles EXE stays occupied (incl. final advance cycle),
  // previous reset, counter values.
  int   m_occ = 0;
  logic m_prev_rst = 1'b1;
  int   m_stall = 0;
  int   m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(AW), .MULTI_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_multi_start(ex_multi_start),
    .mem_dst(mem_dst), .wb_dst(wb_dst),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_branch_taken(mem_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .ex_busy(ex_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [AW-1:0] src);
    if (mem_reg_write && mem_dst != 0 && mem_dst == src) return 2'b10;
    if (wb_reg_write && wb_dst != 0 && wb_dst == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst} = '0;
    {id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read} = '0;
    {ex_multi_start, mem_reg_write, wb_reg_write, mem_branch_taken} = '0;
  endtask

  // One clock: compare all outputs with the model, then advance both.
  // Called just after a negedge with inputs already applied.
  task automatic cyc();
    logic [8:0] e_ctrl;
    logic [1:0] e_frs, e_frt;
    logic       lu;
    int         n_occ, n_st, n_fl;
    #2;
    n_occ = m_occ; n_st = m_stall; n_fl = m_flush;
    lu = ex_mem_read && ex_reg_write && ex_dst != 0 &&
         ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    e_frs = fwd_model(ex_rs);
    e_frt = fwd_model(ex_rt);
    // {pc, if_id_w, id_ex_w, id_ex_bub, ex_mem_bub, if_id_fl, id_ex_fl, ex_mem_fl, busy}
    e_ctrl = 9'b111_00_000_0;
    if (rst || m_prev_rst) begin
      e_ctrl = 9'b000_00_111_0; e_frs = 2'b00; e_frt = 2'b00; n_occ = 0;
      if (rst) begin n_st = 0; n_fl = 0; end
    end else if (mem_branch_taken) begin
      e_ctrl = 9'b111_00_111_0; n_occ = 0; n_fl++;
    end else if (m_occ > 1) begin
      e_ctrl = 9'b000_01_000_1; n_occ = m_occ - 1; n_st++;
    end else if (m_occ == 0 && ex_multi_start && LAT >= 2) begin
      e_ctrl = 9'b000_01_000_1; n_occ = LAT - 1; n_st++;
    end else begin
      n_occ = 0;
      if (lu) begin e_ctrl = 9'b001_10_000_0; n_st++; end
    end
    if (n_st > CMAX) n_st = CMAX;
    if (n_fl > CMAX) n_fl = CMAX;
    chk("ctrl", {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
                 if_id_flush, id_ex_flush, ex_mem_flush, ex_busy}, e_ctrl);
    chk("fwd_rs", fwd_rs, e_frs);
    chk("fwd_rt", fwd_rt, e_frt);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    m_occ = n_occ; m_stall = n_st; m_flush = n_fl; m_prev_rst = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic set_load_use(input logic [AW-1:0] dst);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = dst;
    id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    int nbusy;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset: two cycles asserted, then the tail cycle still in reset shape.
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd", {fwd_rs, fwd_rt}, 4'b0000);
    cyc();

    // Load-use stall, then the same with destination r0.
    set_load_use(5'd8);
    #1;
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_bubble", id_ex_bubble, 1'b1);
    cyc();
    clear_inputs();
    chk("lu_stall_cnt", stall_cnt, 1);
    set_load_use(5'd0);
    #1;
    chk("lu_r0_pc_write", pc_write, 1'b1);
    cyc();
    clear_inputs();

    // Forwarding: MEM beats WB, WB alone, register 0 never forwarded.
    mem_dst = 5'd9; wb_dst = 5'd9; ex_rs = 5'd9; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    #1; chk("fwd_mem", fwd_rs, 2'b10); cyc();
    mem_reg_write = 1'b0;
    #1; chk("fwd_wb", fwd_rs, 2'b01); cyc();
    mem_reg_write = 1'b1; mem_dst = 5'd0; wb_dst = 5'd0; ex_rt = 5'd0;
    #1; chk("fwd_r0", fwd_rt, 2'b00); cyc();
    clear_inputs();

    // Multi-cycle op: 3 stall cycles, 4th advances.
    do_reset();
    nbusy = 0;
    for (int i = 0; i < 4; i++) begin
      ex_multi_start = (i == 0);
      #1;
      if (ex_busy) nbusy++;
      if (i == 3) chk("multi_adv_pc_write", pc_write, 1'b1);
      cyc();
    end
    ex_multi_start = 1'b0;
    chk("multi_busy_cycles", nbusy, 3);
    chk("multi_stall_cnt", stall_cnt, 3);

    // Branch on the 2nd multi stall cycle, with a load-use hazard present.
    do_reset();
    ex_multi_start = 1'b1;
    cyc();
    ex_multi_start = 1'b0;
    mem_branch_taken = 1'b1;
    set_load_use(5'd8);
    #1;
    chk("br_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("br_no_bubble", {id_ex_bubble, ex_mem_bubble}, 2'b00);
    cyc();
    clear_inputs();
    #1;
    chk("br_back_in_run", {pc_write, ex_busy}, 2'b10);
    cyc();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);

    // Saturation: 20 load-use stalls on a 4-bit counter.
    do_reset();
    set_load_use(5'd8);
    for (int i = 0; i < 20; i++) cyc();
    clear_inputs();
    chk("sat_stall_cnt", stall_cnt, 15);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 49) == 0);
      id_rs            = AW'($urandom_range(0, 3));
      id_rt            = AW'($urandom_range(0, 3));
      ex_rs            = AW'($urandom_range(0, 3));
      ex_rt            = AW'($urandom_range(0, 3));
      ex_dst           = AW'($urandom_range(0, 3));
      mem_dst          = AW'($urandom_range(0, 3));
      wb_dst           = AW'($urandom_range(0, 3));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      ex_reg_write     = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      mem_reg_write    = 1'($urandom_range(0, 1));
      wb_reg_write     = 1'($urandom_range(0, 1));
      ex_multi_start   = ($urandom_range(0, 5) == 0);
      mem_branch_taken = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
